// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one full-subtractor cell
// and one borrow flop. Operands and results move over valid/ready handshakes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Counter needs at least one bit even when WIDTH is 1.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             bflop;
    logic             a_msb;
    logic             b_msb;

    logic             ai;
    logic             bi;
    logic             d;
    logic             bout;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor cell operating on the current LSBs and the borrow flop.
    always_comb begin
        ai   = opa[0];
        bi   = opb[0];
        d    = ai ^ bi ^ bflop;
        bout = (~ai & bi) | (~(ai ^ bi) & bflop);
    end

    // New difference bit enters at the MSB so the result ends up LSB-aligned.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = d;
        end else begin : g_res_wn
            assign res_next = {d, res[WIDTH-1:1]};
        end
    endgenerate

    // Control FSM, operand/result shift registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            opa       <= '0;
            opb       <= '0;
            res       <= '0;
            bflop     <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        opa      <= a;
                        opb      <= b;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
                        bflop    <= 1'b0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    res   <= res_next;
                    bflop <= bout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Final cycle: d is the result MSB, bout the unsigned borrow.
                        cnt       <= '0;
                        diff      <= res_next;
                        borrow    <= bout;
                        ovf       <= (a_msb != b_msb) && (d != a_msb);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor
// at WIDTH 1, 8 and 16 against an arithmetic reference model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int checks = 0;

    // Instance index k: 0 -> WIDTH 1, 1 -> WIDTH 8, 2 -> WIDTH 16.
    int widths [3] = '{1, 8, 16};

    logic        iv   [3];
    logic        ordy [3];
    logic        irdy [3];
    logic        ov   [3];
    logic        bo   [3];
    logic        of   [3];
    logic [0:0]  a1, b1, d1;
    logic [7:0]  a8, b8, d8;
    logic [15:0] a16, b16, d16;

    serial_subtractor #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
        .a(a1), .b(b1), .out_valid(ov[0]), .out_ready(ordy[0]),
        .diff(d1), .borrow(bo[0]), .ovf(of[0])
    );
    serial_subtractor #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
        .a(a8), .b(b8), .out_valid(ov[1]), .out_ready(ordy[1]),
        .diff(d8), .borrow(bo[1]), .ovf(of[1])
    );
    serial_subtractor #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
        .a(a16), .b(b16), .out_valid(ov[2]), .out_ready(ordy[2]),
        .diff(d16), .borrow(bo[2]), .ovf(of[2])
    );

    function automatic logic [31:0] get_diff(input int k);
        case (k)
            0:       return {31'b0, d1};
            1:       return {24'b0, d8};
            default: return {16'b0, d16};
        endcase
    endfunction

    task automatic set_in(input int k, input logic v, input logic [31:0] a, input logic [31:0] b);
        iv[k] = v;
        case (k)
            0: begin a1 = a[0:0]; b1 = b[0:0]; end
            1: begin a8 = a[7:0]; b8 = b[7:0]; end
            default: begin a16 = a[15:0]; b16 = b[15:0]; end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer subtraction and signed range test.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ed, output logic eb, output logic eo);
        longint mask, ua, ub, sa, sb, sd, half;
        mask = (64'sd1 <<< w) - 1;
        half = 64'sd1 <<< (w - 1);
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        ed = 32'((ua - ub) & mask);
        eb = (ua < ub);
        sa = (ua >= half) ? ua - (64'sd1 <<< w) : ua;
        sb = (ub >= half) ? ub - (64'sd1 <<< w) : ub;
        sd = sa - sb;
        eo = (sd > half - 1) || (sd < -half);
    endtask

    // One complete transaction: accept, optional busy-time injection, wait,
    // optional back-pressure, then release. All sampling on falling edges.
    task automatic op(input int k, input logic [31:0] a, input logic [31:0] b,
                      input int hold, input bit busy_inj, input string tag);
        logic [31:0] ed;
        logic        eb, eo;
        int          n;
        model(widths[k], a, b, ed, eb, eo);
        vectors++;
        ordy[k] = (hold == 0);
        n = 0;
        while (!irdy[k] && n < 100) begin @(negedge clk); n++; end
        chk({tag, "_accept_timeout"}, 32'(n < 100), 32'd1);
        set_in(k, 1'b1, a, b);
        @(negedge clk);
        if (busy_inj) set_in(k, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555);
        else          set_in(k, 1'b0, $urandom, $urandom);
        n = 0;
        while (!ov[k] && n < 100) begin
            chk({tag, "_busy_in_ready"}, 32'(irdy[k]), 32'd0);
            @(negedge clk);
            n++;
        end
        set_in(k, 1'b0, $urandom, $urandom);
        chk({tag, "_latency"}, n, widths[k]);
        chk({tag, "_diff"}, get_diff(k), ed);
        chk({tag, "_borrow"}, 32'(bo[k]), 32'(eb));
        chk({tag, "_ovf"}, 32'(of[k]), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(ov[k]), 32'd1);
            chk({tag, "_hold_in_ready"}, 32'(irdy[k]), 32'd0);
            chk({tag, "_hold_diff"}, get_diff(k), ed);
            chk({tag, "_hold_borrow"}, 32'(bo[k]), 32'(eb));
            chk({tag, "_hold_ovf"}, 32'(of[k]), 32'(eo));
        end
        ordy[k] = 1'b1;
        @(negedge clk);
        chk({tag, "_release_valid"}, 32'(ov[k]), 32'd0);
        chk({tag, "_release_in_ready"}, 32'(irdy[k]), 32'd1);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            set_in(k, 1'b0, 32'd0, 32'd0);
            ordy[k] = 1'b1;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state on every instance.
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", 32'(irdy[k]), 32'd1);
            chk("rst_out_valid", 32'(ov[k]), 32'd0);
            chk("rst_diff", get_diff(k), 32'd0);
            chk("rst_borrow", 32'(bo[k]), 32'd0);
            chk("rst_ovf", 32'(of[k]), 32'd0);
        end

        // Directed WIDTH=8 cases.
        op(1, 32'h5A, 32'h23, 0, 1'b0, "t1_5a_23");
        op(1, 32'h10, 32'h20, 0, 1'b0, "t2_10_20");
        op(1, 32'h80, 32'h01, 0, 1'b0, "t2_80_01");
        op(1, 32'h7F, 32'hFF, 0, 1'b0, "t2_7f_ff");
        op(1, 32'hFF, 32'hFF, 5, 1'b0, "t3_backpressure");
        op(1, 32'h03, 32'h01, 0, 1'b1, "t4_busy_reject");

        // Reset in the middle of a SHIFT sequence.
        ordy[1] = 1'b1;
        set_in(1, 1'b1, 32'h5A, 32'h23);
        @(negedge clk);
        set_in(1, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_rst_in_ready", 32'(irdy[1]), 32'd1);
        chk("t5_rst_out_valid", 32'(ov[1]), 32'd0);
        chk("t5_rst_diff", get_diff(1), 32'd0);
        chk("t5_rst_borrow", 32'(bo[1]), 32'd0);
        chk("t5_rst_ovf", 32'(of[1]), 32'd0);
        op(1, 32'h01, 32'h02, 0, 1'b0, "t5_fresh");

        // WIDTH=1 exhaustive.
        for (int x = 0; x < 2; x++)
            for (int y = 0; y < 2; y++)
                op(0, 32'(x), 32'(y), 0, 1'b0, "w1_exh");

        // Randomized regression with random back-pressure.
        for (int i = 0; i < 1000; i++) begin
            int k;
            k = i % 3;
            op(k, $urandom, $urandom, int'($urandom_range(0, 3)), 1'b0, "rand");
        end
        // Equal operands and extremes at WIDTH=16.
        op(2, 32'h8000, 32'h8000, 0, 1'b0, "w16_eq");
        op(2, 32'h8000, 32'h0001, 1, 1'b0, "w16_ovf");
        op(2, 32'h0000, 32'hFFFF, 0, 1'b0, "w16_borrow");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
